// File: rtl/gamma_pkg.sv
// gamma_pkg: shared defaults and types for the gamma LUT stream stage.
//   DATA_W_DEF : default pixel component width
//   CH_DEF     : default channel count
//   state_e    : sequencer state (identity init, then normal run)
//   bank_t     : table bank index (active/shadow select)
package gamma_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int CH_DEF     = 3;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef logic bank_t;

endpackage

// File: rtl/gamma_lut_bank.sv
// gamma_lut_bank: double-buffered lookup table for one channel.
// Logical depth is 2^(DATA_W+1) with the bank bit as address MSB; the two
// halves are stored separately so the identity init can fill both banks
// in the same cycle using a per-bank write enable.
//   clk     : clock
//   we      : per-bank write enable, bit b writes bank b
//   wr_addr : write index within a bank
//   wr_data : write value
//   rd_bank : bank select for the read (address MSB)
//   rd_addr : read index within a bank
//   rd_data : registered read data, valid one cycle after the address
module gamma_lut_bank #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic [1:0]        we,
   input  logic [DATA_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_bank,
   input  logic [DATA_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 2 ** DATA_W;

   logic [DATA_W-1:0] mem_q [2][DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Table contents are deliberately not reset.
   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < 2; b++) begin
         if (we[b]) begin
            mem_q[b][wr_addr] <= wr_data;
         end
      end
      rd_data_q <= mem_q[rd_bank][rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/gamma_lut_stream.sv
// gamma_lut_stream: runtime-programmable per-channel gamma correction.
// Each channel owns a double-buffered table; software writes the shadow bank
// and the swap to it happens on a frame start. An init sequencer loads an
// identity curve into every bank after reset. Fixed 2-cycle latency.
//   clk, rst      : clock, synchronous active-high reset
//   cfg_we        : table write strobe (shadow bank, RUN only)
//   cfg_ch        : target channel, values >= CH ignored
//   cfg_addr      : table index
//   cfg_data      : table value
//   cfg_swap      : arm a bank swap for the next frame start
//   bypass        : pass the pixel through unmodified (sampled per pixel)
//   s_valid/s_sof : input pixel valid / first pixel of frame
//   s_data        : input pixel, channel c at [c*DATA_W +: DATA_W]
//   m_valid/m_sof : output pixel valid / frame start
//   m_data        : corrected pixel
//   active_bank   : bank used for lookup
//   swap_pending  : swap armed, waiting for a frame start
//   init_busy     : identity init in progress
module gamma_lut_stream
   import gamma_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int CH     = CH_DEF,
   localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [CH_W-1:0]      cfg_ch,
   input  logic [DATA_W-1:0]    cfg_addr,
   input  logic [DATA_W-1:0]    cfg_data,
   input  logic                 cfg_swap,
   input  logic                 bypass,
   input  logic                 s_valid,
   input  logic                 s_sof,
   input  logic [CH*DATA_W-1:0] s_data,
   output logic                 m_valid,
   output logic                 m_sof,
   output logic [CH*DATA_W-1:0] m_data,
   output logic                 active_bank,
   output logic                 swap_pending,
   output logic                 init_busy
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] cnt_q, cnt_d;
   bank_t             active_q, active_d;
   logic              pend_q, pend_d;

   logic                 v1_q, sof1_q, byp1_q;
   logic [CH*DATA_W-1:0] data1_q;
   logic                 mv_q, msof_q;
   logic [CH*DATA_W-1:0] mdata_q;

   logic                 in_init;
   logic                 swap_now;
   bank_t                rd_bank;
   logic [DATA_W-1:0]    wr_addr, wr_data;
   logic [CH*DATA_W-1:0] lut_out;

   assign in_init  = (state_q == ST_INIT);
   assign swap_now = !in_init && s_valid && s_sof && pend_q;
   // The SOF pixel that triggers the swap already reads the new bank.
   assign rd_bank  = swap_now ? ~active_q : active_q;
   assign wr_addr  = in_init ? cnt_q : cfg_addr;
   assign wr_data  = in_init ? cnt_q : cfg_data;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      pend_d   = pend_q;
      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (swap_now) begin
               active_d = ~active_q;
               pend_d   = cfg_swap;   // simultaneous request re-arms
            end else if (cfg_swap) begin
               pend_d = 1'b1;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [1:0] we;

      always_comb begin
         we = 2'b00;
         if (in_init) begin
            we = 2'b11;
         end else if (cfg_we && (cfg_ch == CH_W'(c))) begin
            // Writes go to the pre-toggle shadow bank, even in a swap cycle.
            we = active_q ? 2'b01 : 2'b10;
         end
      end

      gamma_lut_bank #(
         .DATA_W (DATA_W)
      ) u_bank (
         .clk     (clk),
         .we      (we),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .rd_bank (rd_bank),
         .rd_addr (s_data[c*DATA_W +: DATA_W]),
         .rd_data (lut_out[c*DATA_W +: DATA_W])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_INIT;
         cnt_q    <= '0;
         active_q <= '0;
         pend_q   <= 1'b0;
         v1_q     <= 1'b0;
         sof1_q   <= 1'b0;
         byp1_q   <= 1'b0;
         data1_q  <= '0;
         mv_q     <= 1'b0;
         msof_q   <= 1'b0;
         mdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         v1_q     <= s_valid;
         sof1_q   <= s_valid && s_sof;
         byp1_q   <= bypass || in_init;
         data1_q  <= s_data;
         mv_q     <= v1_q;
         msof_q   <= v1_q && sof1_q;
         if (v1_q) begin
            mdata_q <= byp1_q ? data1_q : lut_out;
         end
      end
   end

   assign m_valid      = mv_q;
   assign m_sof        = msof_q;
   assign m_data       = mdata_q;
   assign active_bank  = active_q;
   assign swap_pending = pend_q;
   assign init_busy    = in_init;

endmodule

// File: tb/tb_gamma_lut_stream.sv
// tb_gamma_lut_stream: directed test of gamma_lut_stream with hand-computed
// expected values (DATA_W=8, CH=3, pixel = {ch2, ch1, ch0}).
module tb_gamma_lut_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [7:0]  cfg_addr;
   logic [7:0]  cfg_data;
   logic        cfg_swap;
   logic        bypass;
   logic        s_valid;
   logic        s_sof;
   logic [23:0] s_data;
   logic        m_valid;
   logic        m_sof;
   logic [23:0] m_data;
   logic        active_bank;
   logic        swap_pending;
   logic        init_busy;

   int n_chk  = 0;
   int n_fail = 0;
   int n_cyc;

   always #5 clk = ~clk;

   gamma_lut_stream #(
      .DATA_W (8),
      .CH     (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_we       (cfg_we),
      .cfg_ch       (cfg_ch),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .cfg_swap     (cfg_swap),
      .bypass       (bypass),
      .s_valid      (s_valid),
      .s_sof        (s_sof),
      .s_data       (s_data),
      .m_valid      (m_valid),
      .m_sof        (m_sof),
      .m_data       (m_data),
      .active_bank  (active_bank),
      .swap_pending (swap_pending),
      .init_busy    (init_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One pixel in, then idle; returns with the pixel at the output.
   task automatic px(input logic [23:0] d, input logic sof, input logic byp);
      s_valid = 1'b1;
      s_sof   = sof;
      bypass  = byp;
      s_data  = d;
      step();
      s_valid = 1'b0;
      s_sof   = 1'b0;
      bypass  = 1'b0;
      step();
   endtask

   task automatic wait_init(output int cycles);
      cycles = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         cycles++;
         if (!init_busy) break;
      end
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0;
      cfg_swap = 1'b0; bypass = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
      step();
      step();
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'h0);
      chk("rst_active_bank", 32'(active_bank), 32'd0);
      chk("rst_swap_pending", 32'(swap_pending), 32'd0);
      chk("rst_init_busy", 32'(init_busy), 32'd1);

      // Identity init takes exactly 256 cycles.
      rst = 1'b0;
      wait_init(n_cyc);
      chk("init_cycles", 32'(n_cyc), 32'd256);

      px(24'hC08040, 1'b0, 1'b0);
      chk("ident_valid", 32'(m_valid), 32'd1);
      chk("ident_data", 32'(m_data), 32'hC08040);
      step();
      chk("idle_valid", 32'(m_valid), 32'd0);
      chk("idle_hold", 32'(m_data), 32'hC08040);

      // Inverse curve into ch0 shadow; active bank stays identity.
      for (int a = 0; a < 256; a++) begin
         cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 8'(a); cfg_data = 8'(255 - a);
         step();
      end
      // Channel 3 does not exist; this write must be dropped.
      cfg_ch = 2'd3; cfg_addr = 8'h20; cfg_data = 8'h99;
      step();
      cfg_we = 1'b0;
      px(24'hC08010, 1'b0, 1'b0);
      chk("noswap_data", 32'(m_data), 32'hC08010);
      chk("noswap_pending", 32'(swap_pending), 32'd0);

      // Arm swap mid-frame; bank changes only at SOF.
      cfg_swap = 1'b1;
      step();
      cfg_swap = 1'b0;
      chk("armed_pending", 32'(swap_pending), 32'd1);
      chk("armed_bank", 32'(active_bank), 32'd0);
      px(24'h804010, 1'b0, 1'b0);
      chk("armed_nonsof", 32'(m_data), 32'h804010);
      chk("armed_bank2", 32'(active_bank), 32'd0);
      px(24'h804010, 1'b1, 1'b0);
      chk("swap_sof_data", 32'(m_data), 32'h8040EF);
      chk("swap_sof_flag", 32'(m_sof), 32'd1);
      chk("swap_bank", 32'(active_bank), 32'd1);
      chk("swap_cleared", 32'(swap_pending), 32'd0);
      px(24'h202020, 1'b0, 1'b0);
      chk("ch3_ignored", 32'(m_data), 32'h2020DF);

      // Per-pixel bypass, back to back.
      s_valid = 1'b1; s_data = 24'h000010; bypass = 1'b1;
      step();
      bypass = 1'b0;
      step();
      s_valid = 1'b0;
      chk("bypass_pix", 32'(m_data), 32'h000010);
      step();
      chk("lookup_pix", 32'(m_data), 32'h0000EF);

      // Armed swap plus simultaneous cfg_swap at SOF re-arms.
      cfg_swap = 1'b1;
      step();
      s_valid = 1'b1; s_sof = 1'b1; s_data = 24'h000010;
      step();
      cfg_swap = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
      chk("rearm_bank", 32'(active_bank), 32'd0);
      chk("rearm_pending", 32'(swap_pending), 32'd1);
      step();
      chk("rearm_data", 32'(m_data), 32'h000010);
      px(24'h000010, 1'b1, 1'b0);
      chk("second_sof_bank", 32'(active_bank), 32'd1);
      chk("second_sof_data", 32'(m_data), 32'h0000EF);
      chk("second_sof_pend", 32'(swap_pending), 32'd0);

      // Reset mid-frame with bank 1 active.
      s_valid = 1'b1; s_data = 24'h000010;
      step();
      rst = 1'b1;
      step();
      chk("midrst_valid", 32'(m_valid), 32'd0);
      chk("midrst_bank", 32'(active_bank), 32'd0);
      chk("midrst_busy", 32'(init_busy), 32'd1);
      s_valid = 1'b0;
      rst = 1'b0;
      // Writes and swap requests during init must be ignored.
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 8'h10; cfg_data = 8'h77; cfg_swap = 1'b1;
      wait_init(n_cyc);
      cfg_we = 1'b0; cfg_swap = 1'b0;
      chk("reinit_cycles", 32'(n_cyc), 32'd256);
      chk("reinit_pending", 32'(swap_pending), 32'd0);
      px(24'h101010, 1'b0, 1'b0);
      chk("reinit_bank0", 32'(m_data), 32'h101010);
      cfg_swap = 1'b1;
      step();
      cfg_swap = 1'b0;
      px(24'h101010, 1'b1, 1'b0);
      chk("reinit_bank1_sel", 32'(active_bank), 32'd1);
      chk("reinit_bank1", 32'(m_data), 32'h101010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
